// File: rtl/logicnet_in_pkg.sv
// logicnet_in_pkg
//   Shared constants, types and helpers for the LogicNets readout input stage.
//   Holds the configuration of the stage (sample width, window length, feature
//   count, quantization width and shift) and the widths derived from it.
//   Optional feature macro used by the stage: LNI_CLIP_CNT_EN.
package logicnet_in_pkg;

  localparam int DATA_W    = 16;
  localparam int AVG_LEN   = 4;   // power of 2, >= 2
  localparam int NUM_FEATS = 3;
  localparam int IN_BITS   = 2;
  localparam int Q_SHIFT   = 8;

  localparam int AVG_SH    = $clog2(AVG_LEN);
  localparam int ACC_W     = DATA_W + AVG_SH;  // sum of AVG_LEN samples cannot overflow
  localparam int VEC_W     = NUM_FEATS * IN_BITS;
  localparam int CODE_MAX  = (1 << IN_BITS) - 1;
  localparam int FEAT_W    = (NUM_FEATS > 1) ? $clog2(NUM_FEATS) : 1;

  typedef enum logic {
    ACCUM = 1'b0,
    OUT   = 1'b1
  } state_t;

  // Clamp the offset value to the unsigned code range [0, CODE_MAX].
  function automatic logic [IN_BITS-1:0] clamp_code(input logic signed [ACC_W:0] v);
    if (v < 0)
      return '0;
    else if (v > CODE_MAX)
      return IN_BITS'(CODE_MAX);
    else
      return v[IN_BITS-1:0];
  endfunction

endpackage

// File: rtl/logicnet_in_quant.sv
// logicnet_in_quant
//   Combinational quantizer for one completed window.
//   Ports:
//     sum_i      signed window sum (ACC_W bits)
//     code_o     quantized feature code (IN_BITS bits)
//     clipped_o  high when the offset value fell outside [0, CODE_MAX]
module logicnet_in_quant
  import logicnet_in_pkg::*;
(
  input  logic signed [ACC_W-1:0] sum_i,
  output logic [IN_BITS-1:0]      code_o,
  output logic                    clipped_o
);

  localparam logic signed [ACC_W:0] OFFSET = (ACC_W+1)'(1 << (IN_BITS-1));

  logic signed [ACC_W:0] sum_x;
  logic signed [ACC_W:0] mean;
  logic signed [ACC_W:0] v;

  // One guard bit so the offset add cannot wrap.
  assign sum_x = {sum_i[ACC_W-1], sum_i};
  // Arithmetic shifts give floor division for negative sums.
  assign mean  = sum_x >>> AVG_SH;
  assign v     = (mean >>> Q_SHIFT) + OFFSET;

  assign code_o    = clamp_code(v);
  assign clipped_o = (v < 0) || (v > CODE_MAX);

endmodule

// File: rtl/logicnet_input_stage.sv
// logicnet_input_stage
//   Box-car averages AVG_LEN signed samples per feature, quantizes each mean to
//   IN_BITS and packs NUM_FEATS features into one vector per frame.
//   Ports:
//     clk, rst_n        clock (rising edge), asynchronous active-low reset
//     s_valid/s_ready   input sample handshake; s_sof resyncs the frame
//     s_data            signed sample (DATA_W)
//     m_valid/m_ready   output vector handshake
//     m_data            packed vector, feature k at [k*IN_BITS +: IN_BITS]
//     clip_cnt          saturating count of clamped features (LNI_CLIP_CNT_EN only)
//   Macro: LNI_CLIP_CNT_EN adds the clip counter and its port.
module logicnet_input_stage
  import logicnet_in_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              s_sof,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
`ifdef LNI_CLIP_CNT_EN
  output logic [15:0]       clip_cnt,
`endif
  output logic [VEC_W-1:0]  m_data
);

  state_t                            state_q, state_d;
  logic signed [ACC_W-1:0]           acc_q, acc_d;
  logic [AVG_SH-1:0]                 samp_q, samp_d;
  logic [FEAT_W-1:0]                 feat_q, feat_d;
  logic [NUM_FEATS-1:0][IN_BITS-1:0] vec_q, vec_d;    // vector under construction
  logic [NUM_FEATS-1:0][IN_BITS-1:0] mdata_q, mdata_d; // presented vector

  logic                    accept;
  logic                    win_done;
  logic signed [ACC_W-1:0] s_ext;
  logic signed [ACC_W-1:0] sum_nxt;
  logic [IN_BITS-1:0]      code;
  logic                    clipped;

  assign s_ready = (state_q == ACCUM);
  assign m_valid = (state_q == OUT);
  assign m_data  = mdata_q;

  assign accept   = s_valid && s_ready;
  assign s_ext    = {{AVG_SH{s_data[DATA_W-1]}}, s_data};
  assign sum_nxt  = acc_q + s_ext;
  // A sof sample always starts a new window, so it never completes one.
  assign win_done = accept && !s_sof && (samp_q == AVG_SH'(AVG_LEN-1));

  logicnet_in_quant u_quant (
    .sum_i     (sum_nxt),
    .code_o    (code),
    .clipped_o (clipped)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    samp_d  = samp_q;
    feat_d  = feat_q;
    vec_d   = vec_q;
    mdata_d = mdata_q;
    case (state_q)
      ACCUM: begin
        if (accept) begin
          if (s_sof) begin
            acc_d  = s_ext;
            samp_d = AVG_SH'(1);
            feat_d = '0;
          end else if (win_done) begin
            acc_d         = '0;
            samp_d        = '0;
            vec_d[feat_q] = code;
            if (feat_q == FEAT_W'(NUM_FEATS-1)) begin
              feat_d  = '0;
              mdata_d = vec_d;
              state_d = OUT;
            end else begin
              feat_d = feat_q + FEAT_W'(1);
            end
          end else begin
            acc_d  = sum_nxt;
            samp_d = samp_q + AVG_SH'(1);
          end
        end
      end
      OUT: begin
        if (m_ready) state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      samp_q  <= '0;
      feat_q  <= '0;
      vec_q   <= '0;
      mdata_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      samp_q  <= samp_d;
      feat_q  <= feat_d;
      vec_q   <= vec_d;
      mdata_q <= mdata_d;
    end
  end

`ifdef LNI_CLIP_CNT_EN
  logic [15:0] clip_q, clip_d;

  always_comb begin
    clip_d = clip_q;
    if (win_done && clipped && (clip_q != 16'hFFFF))
      clip_d = clip_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) clip_q <= '0;
    else        clip_q <= clip_d;
  end

  assign clip_cnt = clip_q;
`else
  // Clip flag only feeds the optional counter.
  logic unused_clip;
  assign unused_clip = clipped;
`endif

endmodule

// File: tb/tb_logicnet_input_stage.sv
// tb_logicnet_input_stage
//   Directed self-checking bench for logicnet_input_stage (default parameters).
//   Define LNI_CLIP_CNT_EN to also exercise the clip counter.
module tb_logicnet_input_stage;
  import logicnet_in_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic              s_sof = 1'b0;
  logic [DATA_W-1:0] s_data = '0;
  logic              m_valid;
  logic              m_ready = 1'b1;
  logic [VEC_W-1:0]  m_data;
`ifdef LNI_CLIP_CNT_EN
  logic [15:0]       clip_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  logicnet_input_stage dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_sof   (s_sof),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
`ifdef LNI_CLIP_CNT_EN
    .clip_cnt(clip_cnt),
`endif
    .m_data  (m_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1; presents one sample for one edge, returns at next posedge+1.
  task automatic send(input int d, input logic sof);
    s_valid = 1'b1;
    s_data  = d[DATA_W-1:0];
    s_sof   = sof;
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_sof   = 1'b0;
  endtask

  task automatic send4(input int d);
    for (int i = 0; i < 4; i++) send(d, 1'b0);
  endtask

  // Frame {0 x4},{256 x4},{-1024 x4} -> codes 2,3,0 -> 6'b00_11_10
  task automatic frame1();
    send4(0);
    send4(256);
    for (int i = 0; i < 3; i++) send(-1024, 1'b0);
    chk("pre_last_mvalid", 32'(m_valid), 32'd0);
    send(-1024, 1'b0);
  endtask

  task automatic cycle();
    @(posedge clk); #1;
  endtask

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data",  32'(m_data),  32'd0);
    rst_n = 1'b1;
    cycle();

    // 1: basic frame, m_ready=1, 1-cycle latency
    m_ready = 1'b1;
    frame1();
    chk("t1_m_valid", 32'(m_valid), 32'd1);
    chk("t1_m_data",  32'(m_data),  32'b00_11_10);
    chk("t1_s_ready", 32'(s_ready), 32'd0);
    cycle();
    chk("t1_xfer_m_valid", 32'(m_valid), 32'd0);
    chk("t1_xfer_s_ready", 32'(s_ready), 32'd1);

    // 2: backpressure, stray sof while in OUT must be ignored
    m_ready = 1'b0;
    frame1();
    s_valid = 1'b1; s_sof = 1'b1; s_data = 16'd777;
    for (int i = 0; i < 5; i++) begin
      chk("t2_hold_m_valid", 32'(m_valid), 32'd1);
      chk("t2_hold_m_data",  32'(m_data),  32'b00_11_10);
      chk("t2_hold_s_ready", 32'(s_ready), 32'd0);
      cycle();
    end
    s_valid = 1'b0; s_sof = 1'b0;
    m_ready = 1'b1;
    chk("t2_pre_rel_m_valid", 32'(m_valid), 32'd1);
    cycle();
    chk("t2_rel_m_valid", 32'(m_valid), 32'd0);
    chk("t2_rel_s_ready", 32'(s_ready), 32'd1);

    // 3: floor rounding: {255,256,256,256}->2, {-1,0,0,0}->1, {0..}->2
    send(255, 1'b0); send(256, 1'b0); send(256, 1'b0); send(256, 1'b0);
    send(-1, 1'b0);  send(0, 1'b0);   send(0, 1'b0);   send(0, 1'b0);
    send4(0);
    chk("t3_m_valid", 32'(m_valid), 32'd1);
    chk("t3_m_data",  32'(m_data),  32'b10_01_10);
    cycle();
    chk("t3_xfer_m_valid", 32'(m_valid), 32'd0);

    // 4: sof resync after 6 samples; partial frame never emitted
    for (int i = 0; i < 6; i++) send(1000, 1'b0);
    send(100, 1'b1);
    for (int i = 0; i < 10; i++) begin
      send(100, 1'b0);
      chk("t4_no_early_vec", 32'(m_valid), 32'd0);
    end
    send(100, 1'b0);
    chk("t4_m_valid", 32'(m_valid), 32'd1);
    chk("t4_m_data",  32'(m_data),  32'b10_10_10);
    cycle();
    chk("t4_xfer_m_valid", 32'(m_valid), 32'd0);

    // 5: async reset mid-OUT
    m_ready = 1'b0;
    frame1();
    chk("t5_m_valid_pre", 32'(m_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_m_valid", 32'(m_valid), 32'd0);
    chk("t5_rst_m_data",  32'(m_data),  32'd0);
    chk("t5_rst_s_ready", 32'(s_ready), 32'd1);
    #1;
    rst_n = 1'b1;
    m_ready = 1'b1;
    cycle();
    frame1();
    chk("t5_post_m_valid", 32'(m_valid), 32'd1);
    chk("t5_post_m_data",  32'(m_data),  32'b00_11_10);
    cycle();

`ifdef LNI_CLIP_CNT_EN
    // 6: clip counter, one clamp per frame
    rst_n = 1'b0;
    #1;
    chk("t6_rst_clip", 32'(clip_cnt), 32'd0);
    rst_n = 1'b1;
    cycle();
    for (int f = 0; f < 3; f++) begin
      frame1();
      chk("t6_frame_clip", 32'(clip_cnt), 32'(f + 1));
      cycle();
    end
    chk("t6_clip_total", 32'(clip_cnt), 32'd3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
